systolic_nxn_engine: RTL and testbench

- Parametrised successor to the fixed 2x2 systolic core: an NxN output-stationary signed MAC array.
- Has its own command FSM, internal input skewing, variable inner dimension K, a valid/ready input stream, saturating accumulators and an addressed result read port.
- Sits behind the memory-mapped SYSTOLIC host wrapper. The host streams one A column and one B row per beat, then reads the NxN C = A·B results.

---
 rtl/systolic_pkg.sv | 42 ++++
 rtl/systolic_pe.sv | 49 ++++
 rtl/systolic_nxn_engine.sv | 169 ++++++++++++++++
 tb/tb_systolic_nxn_engine.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared types and helpers for the NxN systolic engine: FSM states,
// the saturating accumulate used by every PE, and the drain length.
package systolic_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

  // Working width of the saturating adder; accumulators up to 62 bits fit
  // without the intermediate sum itself overflowing.
  localparam int SAT_W = 64;

  // Terminal count of the drain counter: last PE sees the final beat
  // 2N-1 edges after it is accepted, DONE follows one edge later.
  function automatic int drain_len(input int n);
    return 2 * n - 1;
  endfunction

  function automatic logic signed [SAT_W-1:0] sat_add(
    input  logic signed [SAT_W-1:0] x,
    input  logic signed [SAT_W-1:0] y,
    input  int                      w,
    output logic                    ovf
  );
    logic signed [SAT_W-1:0] sum;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    logic signed [SAT_W-1:0] res;
    sum = x + y;
    hi  = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo  = -hi - 64'sd1;
    ovf = 1'b0;
    res = sum;
    if (sum > hi) begin
      res = hi;
      ovf = 1'b1;
    end else if (sum < lo) begin
      res = lo;
      ovf = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/systolic_pe.sv
// One output-stationary processing element: forwards a east and b south
// with one register each and accumulates a*b with saturation.
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int DW   = 16,
  parameter int ACCW = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear_acc,
  input  logic [DW-1:0]   a_in,
  input  logic [DW-1:0]   b_in,
  output logic [DW-1:0]   a_out,
  output logic [DW-1:0]   b_out,
  output logic [ACCW-1:0] acc,
  output logic            sat_evt
);

  logic signed [2*DW-1:0] prod;
  logic [ACCW-1:0]        acc_next;
  logic                   ovf;

  assign prod = $signed(a_in) * $signed(b_in);

  always_comb begin
    ovf      = 1'b0;
    acc_next = ACCW'(sat_add(SAT_W'($signed(acc)), SAT_W'(prod), ACCW, ovf));
  end

  assign sat_evt = ovf & ~clear_acc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else if (clear_acc) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else begin
      a_out <= a_in;
      b_out <= b_in;
      acc   <= acc_next;
    end
  end

endmodule

// File: rtl/systolic_nxn_engine.sv
// NxN output-stationary signed MAC array with input skewing, command FSM,
// valid/ready beat stream, sticky saturation flag and registered read port.
module systolic_nxn_engine
  import systolic_pkg::*;
#(
  parameter int N    = 2,
  parameter int DW   = 16,
  parameter int ACCW = 32,
  parameter int KW   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 clear,
  input  logic [KW-1:0]        k_len,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*DW-1:0]      a_col,
  input  logic [N*DW-1:0]      b_row,
  output logic                 busy,
  output logic                 done,
  output logic                 sat,
  input  logic [$clog2(N)-1:0] rd_row,
  input  logic [$clog2(N)-1:0] rd_col,
  output logic [ACCW-1:0]      rd_data
);

  localparam int DRAIN_LEN = drain_len(N);
  localparam int DCW       = $clog2(2 * N);

  state_t          state;
  logic [KW-1:0]   k_reg;
  logic [KW-1:0]   beat_cnt;
  logic [DCW-1:0]  drain_cnt;
  logic            accept;
  logic            clear_acc;
  logic            sat_any;
  logic [N*N-1:0]  sat_vec;

  logic [DW-1:0]   a_h [N][N+1];
  logic [DW-1:0]   b_v [N+1][N];
  logic [ACCW-1:0] acc_grid [N][N];
  logic [DW-1:0]   a_east_unused [N];
  logic [DW-1:0]   b_south_unused [N];

  assign accept    = in_valid & in_ready;
  assign clear_acc = clear | (start & (state == IDLE || state == DONE));
  assign sat_any   = |sat_vec;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      k_reg     <= '0;
      beat_cnt  <= '0;
      drain_cnt <= '0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sat       <= 1'b0;
    end else if (clear) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      drain_cnt <= '0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sat       <= 1'b0;
    end else begin
      sat <= sat | sat_any;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            k_reg     <= k_len;
            beat_cnt  <= '0;
            drain_cnt <= '0;
            sat       <= 1'b0;
            if (k_len == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state    <= LOAD;
              done     <= 1'b0;
              in_ready <= 1'b1;
              busy     <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (accept) begin
            beat_cnt <= beat_cnt + KW'(1);
            if (beat_cnt == k_reg - KW'(1)) begin
              state    <= DRAIN;
              in_ready <= 1'b0;
            end
          end
        end
        DRAIN: begin
          drain_cnt <= drain_cnt + DCW'(1);
          if (drain_cnt == DCW'(DRAIN_LEN)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Row/column gi is delayed gi extra cycles; non-accepting edges inject zero.
  genvar gi, gj;
  generate
    for (gi = 0; gi < N; gi++) begin : g_skew
      logic [DW-1:0] a_sr [gi+1];
      logic [DW-1:0] b_sr [gi+1];

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int s = 0; s <= gi; s++) begin
            a_sr[s] <= '0;
            b_sr[s] <= '0;
          end
        end else if (clear_acc) begin
          for (int s = 0; s <= gi; s++) begin
            a_sr[s] <= '0;
            b_sr[s] <= '0;
          end
        end else begin
          a_sr[0] <= accept ? a_col[gi*DW +: DW] : '0;
          b_sr[0] <= accept ? b_row[gi*DW +: DW] : '0;
          for (int s = 1; s <= gi; s++) begin
            a_sr[s] <= a_sr[s-1];
            b_sr[s] <= b_sr[s-1];
          end
        end
      end

      assign a_h[gi][0]         = a_sr[gi];
      assign b_v[0][gi]         = b_sr[gi];
      assign a_east_unused[gi]  = a_h[gi][N];
      assign b_south_unused[gi] = b_v[N][gi];
    end

    for (gi = 0; gi < N; gi++) begin : g_row
      for (gj = 0; gj < N; gj++) begin : g_col
        systolic_pe #(.DW(DW), .ACCW(ACCW)) u_pe (
          .clk       (clk),
          .reset     (reset),
          .clear_acc (clear_acc),
          .a_in      (a_h[gi][gj]),
          .b_in      (b_v[gi][gj]),
          .a_out     (a_h[gi][gj+1]),
          .b_out     (b_v[gi+1][gj]),
          .acc       (acc_grid[gi][gj]),
          .sat_evt   (sat_vec[gi*N+gj])
        );
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data <= '0;
    end else begin
      rd_data <= acc_grid[rd_row][rd_col];
    end
  end

endmodule

// File: tb/tb_systolic_nxn_engine.sv
// Directed bench for systolic_nxn_engine: a 2x2 instance for the job,
// bubble, saturation, abort and reset cases, and a 4x4 identity job.
module tb_systolic_nxn_engine;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        start = 1'b0, clear = 1'b0, in_valid = 1'b0;
  logic [7:0]  k_len = '0;
  logic [31:0] a_col = '0, b_row = '0;
  logic        rd_row = 1'b0, rd_col = 1'b0;
  logic        in_ready, busy, done, sat;
  logic [31:0] rd_data;

  logic        start4 = 1'b0, clear4 = 1'b0, in_valid4 = 1'b0;
  logic [7:0]  k_len4 = '0;
  logic [63:0] a_col4 = '0, b_row4 = '0;
  logic [1:0]  rd_row4 = '0, rd_col4 = '0;
  logic        in_ready4, busy4, done4, sat4;
  logic [31:0] rd_data4;

  int checks = 0;
  int errors = 0;
  logic [31:0] av [8];
  logic [31:0] bv [8];

  systolic_nxn_engine #(.N(2), .DW(16), .ACCW(32), .KW(8)) dut (
    .clk(clk), .reset(reset), .start(start), .clear(clear), .k_len(k_len),
    .in_valid(in_valid), .in_ready(in_ready), .a_col(a_col), .b_row(b_row),
    .busy(busy), .done(done), .sat(sat),
    .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data)
  );

  systolic_nxn_engine #(.N(4), .DW(16), .ACCW(32), .KW(8)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .clear(clear4), .k_len(k_len4),
    .in_valid(in_valid4), .in_ready(in_ready4), .a_col(a_col4), .b_row(b_row4),
    .busy(busy4), .done(done4), .sat(sat4),
    .rd_row(rd_row4), .rd_col(rd_col4), .rd_data(rd_data4)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic read_c(input int r, input int c, input logic [31:0] exp, input string tag);
    rd_row = r[0];
    rd_col = c[0];
    @(posedge clk); #1;
    $display("read %s C[%0d][%0d] = %0h", tag, r, c, rd_data);
    check(tag, rd_data, exp);
  endtask

  task automatic check_c4(input logic [31:0] e00, input logic [31:0] e01,
                          input logic [31:0] e10, input logic [31:0] e11, input string tag);
    read_c(0, 0, e00, tag);
    read_c(0, 1, e01, tag);
    read_c(1, 0, e10, tag);
    read_c(1, 1, e11, tag);
  endtask

  // Starts a job of k beats from av/bv; gap idle cycles between beats carry
  // garbage data with in_valid low; glitch fires a stray start during LOAD.
  task automatic load_beats(input int k, input int gap, input bit glitch);
    start = 1'b1;
    k_len = k[7:0];
    @(posedge clk); #1;
    start = 1'b0;
    for (int b = 0; b < k; b++) begin
      in_valid = 1'b1;
      a_col    = av[b];
      b_row    = bv[b];
      if (glitch && b == 2) begin
        start = 1'b1;
        k_len = 8'd1;
      end
      check("in_ready_load", in_ready, 1);
      @(posedge clk); #1;
      start    = 1'b0;
      in_valid = 1'b0;
      a_col    = 32'hFFFF_FFFF;
      b_row    = 32'hFFFF_FFFF;
      if (b < k - 1) begin
        for (int g = 0; g < gap; g++) begin
          check("in_ready_bubble", in_ready, 1);
          @(posedge clk); #1;
        end
      end
    end
    $display("job k=%0d gap=%0d loaded", k, gap);
  endtask

  task automatic wait_done(input int exp_lat);
    int cnt;
    cnt = 0;
    while (!done && cnt < 40) begin
      @(posedge clk); #1;
      cnt++;
    end
    check("done_latency", cnt, exp_lat);
    check("busy_at_done", busy, 0);
  endtask

  task automatic set_job1();
    av[0] = {16'd3, 16'd1}; bv[0] = {16'd6, 16'd5};
    av[1] = {16'd4, 16'd2}; bv[1] = {16'd8, 16'd7};
  endtask

  initial begin
    int cnt;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sat", sat, 0);
    check("rst_rd_data", rd_data, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    set_job1();
    load_beats(2, 0, 1'b0);
    wait_done(4);
    check_c4(32'd19, 32'd22, 32'd43, 32'd50, "job1");
    check("job1_sat", sat, 0);

    load_beats(2, 3, 1'b0);
    wait_done(4);
    check_c4(32'd19, 32'd22, 32'd43, 32'd50, "bubbles");

    for (int b = 0; b < 3; b++) begin
      av[b] = {16'h7FFF, 16'h7FFF};
      bv[b] = {16'h7FFF, 16'h7FFF};
    end
    load_beats(3, 0, 1'b0);
    wait_done(4);
    check_c4(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, "sat_pos");
    check("sat_pos_flag", sat, 1);

    for (int b = 0; b < 3; b++) av[b] = {16'h8000, 16'h8000};
    load_beats(3, 0, 1'b0);
    wait_done(4);
    check_c4(32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, "sat_neg");
    check("sat_neg_flag", sat, 1);

    start = 1'b1;
    k_len = 8'd0;
    @(posedge clk); #1;
    start = 1'b0;
    check("k0_done", done, 1);
    check("k0_busy", busy, 0);
    check("k0_sat", sat, 0);
    check_c4(32'd0, 32'd0, 32'd0, 32'd0, "k0");

    av[0] = {16'd0, 16'd1}; bv[0] = {16'd2, 16'd1};
    av[1] = {16'd3, 16'd0}; bv[1] = {16'd1, 16'd3};
    av[2] = {16'd1, 16'd2}; bv[2] = {16'd0, 16'd2};
    av[3] = {16'd2, 16'd1}; bv[3] = {16'd1, 16'd1};
    load_beats(4, 0, 1'b1);
    wait_done(4);
    check_c4(32'd6, 32'd3, 32'd13, 32'd5, "k4_stray_start");

    set_job1();
    load_beats(2, 0, 1'b0);
    @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    check("clr_done", done, 0);
    check("clr_busy", busy, 0);
    check("clr_in_ready", in_ready, 0);
    check_c4(32'd0, 32'd0, 32'd0, 32'd0, "after_clear");
    load_beats(2, 0, 1'b0);
    wait_done(4);
    check_c4(32'd19, 32'd22, 32'd43, 32'd50, "post_clear");

    start = 1'b1;
    k_len = 8'd2;
    @(posedge clk); #1;
    start    = 1'b0;
    in_valid = 1'b1;
    a_col    = av[0];
    b_row    = bv[0];
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    #2;
    check("arst_busy", busy, 0);
    check("arst_in_ready", in_ready, 0);
    check("arst_done", done, 0);
    reset = 1'b1;
    check_c4(32'd0, 32'd0, 32'd0, 32'd0, "after_reset");
    load_beats(2, 0, 1'b0);
    wait_done(4);
    check_c4(32'd19, 32'd22, 32'd43, 32'd50, "post_reset");

    start4 = 1'b1;
    k_len4 = 8'd4;
    @(posedge clk); #1;
    start4 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid4 = 1'b1;
      a_col4    = 64'd1 << (16 * k);
      for (int j = 0; j < 4; j++) b_row4[j*16 +: 16] = 16'(4 * k + j + 1);
      check("n4_in_ready", in_ready4, 1);
      @(posedge clk); #1;
    end
    in_valid4 = 1'b0;
    $display("job n4 k=4 loaded");
    cnt = 0;
    while (!done4 && cnt < 40) begin
      @(posedge clk); #1;
      cnt++;
    end
    check("n4_done_latency", cnt, 8);
    rd_row4 = 2'd0;
    rd_col4 = 2'd0;
    @(posedge clk); #1;
    check("n4_rd00", rd_data4, 1);
    rd_row4 = 2'd3;
    rd_col4 = 2'd3;
    #1;
    check("n4_rd_lag_hold", rd_data4, 1);
    @(posedge clk); #1;
    check("n4_rd33", rd_data4, 16);
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        rd_row4 = r[1:0];
        rd_col4 = c[1:0];
        @(posedge clk); #1;
        $display("read n4 C[%0d][%0d] = %0h", r, c, rd_data4);
        check("n4_c", rd_data4, 64'(4 * r + c + 1));
      end
    end
    check("n4_sat", sat4, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
